// File: rtl/pp_symbol_sequencer.sv
// pp_symbol_sequencer: drives cs/rw of a parallel width-down buffer, one load then CHUNKS-1 shifts per word
//   clk, rst          : clock, synchronous active-high reset
//   i_en              : symbol timer run enable
//   i_word/_valid     : upstream word and its valid; o_word_ready is the combinational accept
//   i_flow            : buffer flow output (last chunk showing)
//   o_buf_word        : registered word to the buffer parallel input
//   o_buf_cs/o_buf_rw : one-cycle chip select pulse; rw=1 load, 0 shift (held between pulses)
//   o_sym_strobe      : new chunk valid on the buffer output this cycle
//   o_underrun        : pulse, a load was due with no word available
//   o_sync_err        : sticky chunk-count versus flow disagreement
//   o_underrun_cnt    : saturating underrun count, present only with PP_SEQ_UNDERRUN_CNT_EN defined
module pp_symbol_sequencer #(
    parameter int WIDTH_I = 16,
    parameter int WIDTH_O = 4,
    parameter int DIV     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [WIDTH_I-1:0] i_word,
    input  logic               i_word_valid,
    output logic               o_word_ready,
    input  logic               i_flow,
    output logic [WIDTH_I-1:0] o_buf_word,
    output logic               o_buf_cs,
    output logic               o_buf_rw,
    output logic               o_sym_strobe,
    output logic               o_underrun,
    output logic               o_sync_err
`ifdef PP_SEQ_UNDERRUN_CNT_EN
    ,
    output logic [15:0]        o_underrun_cnt
`endif
);
    localparam int CHUNKS = WIDTH_I / WIDTH_O;
    localparam int TW     = $clog2(DIV);
    localparam int CW     = $clog2(CHUNKS);

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TW-1:0]      r_timer;
    logic [CW-1:0]      r_chunks;
    logic [CW-1:0]      w_chunks_nxt;
    logic [WIDTH_I-1:0] r_buf_word;
    logic               r_cs, r_rw, r_strobe, r_underrun, r_sync_err;
    logic               w_tick, w_due, w_load, w_shift, w_flow_bad;

    // Reset gates the tick so nothing is accepted or issued in a reset cycle.
    assign w_tick = i_en && !rst && (r_timer == TW'(DIV - 1));

    always_comb begin
        w_due        = w_tick && (r_state == S_EMPTY || r_chunks == '0);
        w_load       = w_due && i_word_valid;
        w_shift      = w_tick && !w_due;
        w_flow_bad   = w_tick && (r_state == S_HOLD) && ((r_chunks == '0) != i_flow);
        w_state_nxt  = w_load ? S_HOLD : (w_due ? S_EMPTY : r_state);
        w_chunks_nxt = w_load ? CW'(CHUNKS - 1) : (w_shift ? r_chunks - CW'(1) : r_chunks);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_timer    <= '0;
            r_chunks   <= '0;
            r_buf_word <= '0;
            r_cs       <= 1'b0;
            r_rw       <= 1'b0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= (!i_en || r_timer == TW'(DIV - 1)) ? '0 : r_timer + TW'(1);
            r_chunks   <= w_chunks_nxt;
            r_buf_word <= w_load ? i_word : r_buf_word;
            r_cs       <= w_load || w_shift;
            r_rw       <= (w_load || w_shift) ? w_load : r_rw;
            // The buffer acts on cs at the end of the pulse cycle, so its output is new one cycle later.
            r_strobe   <= r_cs;
            r_underrun <= w_due && !i_word_valid;
            r_sync_err <= r_sync_err || w_flow_bad;
        end
    end

`ifdef PP_SEQ_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_underrun_cnt <= '0;
        else if (w_due && !i_word_valid && r_underrun_cnt != 16'hFFFF)
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end

    assign o_underrun_cnt = r_underrun_cnt;
`endif

    assign o_word_ready = w_load;
    assign o_buf_word   = r_buf_word;
    assign o_buf_cs     = r_cs;
    assign o_buf_rw     = r_rw;
    assign o_sym_strobe = r_strobe;
    assign o_underrun   = r_underrun;
    assign o_sync_err   = r_sync_err;
endmodule
